// File: rtl/norm_frame_sequencer_if.sv
`default_nettype none
// =============================================================================
// Module   : norm_frame_sequencer_if
// Purpose  : Host, stage-control and stream-snoop signals of the frame sequencer.
// Revision : 1.0  initial release
// =============================================================================
interface norm_frame_sequencer_if #(
  parameter int PIXEL_BIT_WIDTH = 10
);
  logic                       frame_start;
  logic                       frame_busy;
  logic                       frame_done;
  logic                       frame_error;
  logic [15:0]                frame_count;
  logic                       cf_ap_start;
  logic                       cf_ap_ready;
  logic                       cf_ap_done;
  logic                       nr_ap_start;
  logic                       nr_ap_ready;
  logic                       cf_mon_tvalid;
  logic                       cf_mon_tready;
  logic [PIXEL_BIT_WIDTH-1:0] cf_mon_tdata;
  logic                       nr_mon_tvalid;
  logic                       nr_mon_tready;
  logic [PIXEL_BIT_WIDTH-1:0] norm_denominator;

  // The sequencer itself
  modport master (
    input  frame_start, cf_ap_ready, cf_ap_done, nr_ap_ready,
           cf_mon_tvalid, cf_mon_tready, cf_mon_tdata,
           nr_mon_tvalid, nr_mon_tready,
    output frame_busy, frame_done, frame_error, frame_count,
           cf_ap_start, nr_ap_start, norm_denominator
  );

  // Host plus the two pipeline stages
  modport slave (
    output frame_start, cf_ap_ready, cf_ap_done, nr_ap_ready,
           cf_mon_tvalid, cf_mon_tready, cf_mon_tdata,
           nr_mon_tvalid, nr_mon_tready,
    input  frame_busy, frame_done, frame_error, frame_count,
           cf_ap_start, nr_ap_start, norm_denominator
  );
endinterface
`default_nettype wire

// File: rtl/norm_frame_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : norm_frame_sequencer
// Purpose  : Launches crop filter + normalizer, snoops the crop peak as the
//            normalizer denominator, counts output beats to frame completion.
//            Optional stall watchdog: define NORM_SEQ_WATCHDOG_EN.
// Revision : 1.0  initial release
// =============================================================================
module norm_frame_sequencer #(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int OUT_ROWS        = 10,
  parameter int OUT_COLS        = 10,
  parameter int WDOG_CYCLES     = 65535
) (
  input wire clk,
  input wire reset,
  norm_frame_sequencer_if.master bus
);
  localparam int                         c_n         = OUT_ROWS * OUT_COLS;
  localparam int                         c_cnt_w     = $clog2(c_n + 1);
  localparam logic [c_cnt_w-1:0]         c_n_cnt     = c_cnt_w'(c_n);
  localparam logic [c_cnt_w-1:0]         c_cnt_one   = c_cnt_w'(1);
  localparam logic [PIXEL_BIT_WIDTH-1:0] c_den_one   = PIXEL_BIT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_CROP   = 3'd2,
    S_NORM   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [PIXEL_BIT_WIDTH-1:0] r_peak;
  logic [PIXEL_BIT_WIDTH-1:0] r_den;
  logic [PIXEL_BIT_WIDTH-1:0] w_peak_in;
  logic [PIXEL_BIT_WIDTH-1:0] w_den;
  logic [c_cnt_w-1:0]         r_beat_cnt;
  logic [c_cnt_w-1:0]         w_beat_cnt_nxt;
  logic [15:0]                r_frame_count;
  logic                       w_cf_beat;
  logic                       w_nr_beat;
  logic                       w_last;

  assign w_cf_beat = bus.cf_mon_tvalid & bus.cf_mon_tready;
  assign w_nr_beat = bus.nr_mon_tvalid & bus.nr_mon_tready;

  // Counter saturates at N so surplus beats cannot wrap it back below N
  assign w_beat_cnt_nxt = (w_nr_beat && (r_beat_cnt != c_n_cnt)) ? r_beat_cnt + c_cnt_one
                                                                 : r_beat_cnt;
  assign w_last         = (w_beat_cnt_nxt == c_n_cnt);

  // Peak including a beat landing in the same cycle as cf_ap_done
  assign w_peak_in = (w_cf_beat && (bus.cf_mon_tdata > r_peak)) ? bus.cf_mon_tdata : r_peak;
  assign w_den     = (w_peak_in == '0) ? c_den_one : w_peak_in;

`ifdef NORM_SEQ_WATCHDOG_EN
  localparam int                  c_wdog_w    = $clog2(WDOG_CYCLES + 1);
  localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(WDOG_CYCLES - 1);
  localparam logic [c_wdog_w-1:0] c_wdog_one  = c_wdog_w'(1);

  logic [c_wdog_w-1:0] r_wdog;
  logic                w_wdog_active;
  logic                w_wdog_clr;
  logic                w_wdog_hit;

  // Entering CROP (from LAUNCH) or NORM (on cf_ap_done) always passes
  // through a clearing condition, so state entry needs no extra tracking.
  assign w_wdog_active = (r_state == S_CROP) || (r_state == S_NORM);
  assign w_wdog_clr    = w_cf_beat | w_nr_beat | bus.cf_ap_done;
  assign w_wdog_hit    = w_wdog_active && !w_wdog_clr && (r_wdog == c_wdog_last);

  always_ff @(posedge clk) begin
    if (reset || !w_wdog_active || w_wdog_clr) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + c_wdog_one;
    end
  end

  assign bus.frame_error = w_wdog_hit;
`else
  assign bus.frame_error = 1'b0 & (WDOG_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.frame_start && bus.cf_ap_ready && bus.nr_ap_ready) begin
          w_next = S_LAUNCH;
        end
      end
      S_LAUNCH: w_next = S_CROP;
      S_CROP: begin
        if (bus.cf_ap_done) begin
          w_next = w_last ? S_DONE : S_NORM;
        end
      end
      S_NORM: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
`ifdef NORM_SEQ_WATCHDOG_EN
    if (w_wdog_hit) begin
      w_next = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_peak        <= '0;
      r_beat_cnt    <= '0;
      r_den         <= c_den_one;
      r_frame_count <= '0;
    end else begin
      case (r_state)
        S_LAUNCH: begin
          r_peak     <= '0;
          r_beat_cnt <= '0;
        end
        S_CROP: begin
          r_peak     <= w_peak_in;
          r_beat_cnt <= w_beat_cnt_nxt;
          if (bus.cf_ap_done) begin
            r_den <= w_den;
          end
        end
        S_NORM: r_beat_cnt <= w_beat_cnt_nxt;
        S_DONE: r_frame_count <= r_frame_count + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.frame_busy       = (r_state != S_IDLE);
  assign bus.frame_done       = (r_state == S_DONE);
  assign bus.cf_ap_start      = (r_state == S_LAUNCH);
  assign bus.nr_ap_start      = (r_state == S_LAUNCH);
  assign bus.frame_count      = r_frame_count;
  assign bus.norm_denominator = r_den;

endmodule
`default_nettype wire
